// File: rtl/sigma_delta_decimator_if.sv
// sigma_delta_decimator_if: bitstream input and decimated sample handshake for sigma_delta_decimator.
interface sigma_delta_decimator_if #(parameter int BW = 16);
    logic          bit_i;
    logic          bit_en_i;
    logic [BW-1:0] sample_o;
    logic          sample_valid_o;
    logic          sample_ready_i;
    logic          overrun_o;
    modport master (output bit_i, bit_en_i, sample_ready_i, input sample_o, sample_valid_o, overrun_o);
    modport slave  (input bit_i, bit_en_i, sample_ready_i, output sample_o, sample_valid_o, overrun_o);
endinterface

// File: rtl/sigma_delta_decimator.sv
// sigma_delta_decimator: 3rd-order CIC decimator (ratio 2^LOG2R) with a valid/ready sample register.
// Define SIGMA_DELTA_DECIM_ROUND_EN to round half up before the output shift instead of truncating.
module sigma_delta_decimator #(
    parameter int BW    = 16,
    parameter int LOG2R = 6
) (
    input logic clk,
    input logic rst_n,
    sigma_delta_decimator_if.slave io
);
    localparam int W = 3*LOG2R + 2;
    localparam int S = 3*LOG2R - (BW-1);
`ifdef SIGMA_DELTA_DECIM_ROUND_EN
    localparam logic signed [W:0] RND = (W+1)'((2**S)/2);
`else
    localparam logic signed [W:0] RND = '0;
`endif
    localparam logic signed [W:0] MAXV = (W+1)'(2**(BW-1) - 1);
    localparam logic signed [W:0] MINV = -MAXV - 1;
    logic signed [W-1:0] i1, i2, i3, d1, d2, d3, c1, c2, c3, x;
    logic signed [W:0]   ext, sh;
    logic [BW-1:0]       sat;
    logic [LOG2R-1:0]    phase;
    logic                dec;
    assign x = io.bit_i ? W'(1) : '1;
    // Integrators wrap freely; the comb differences stay exact because the true result fits in W bits.
    always_comb begin
        c1  = i3 - d1;
        c2  = c1 - d2;
        c3  = c2 - d3;
        ext = $signed({c3[W-1], c3}) + RND;
        sh  = ext >>> S;
        sat = (sh > MAXV) ? MAXV[BW-1:0] : (sh < MINV) ? MINV[BW-1:0] : sh[BW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            phase <= '0;
            dec <= 1'b0;
            io.sample_o <= '0;
            io.sample_valid_o <= 1'b0;
            io.overrun_o <= 1'b0;
        end else begin
            if (io.bit_en_i) begin
                i1 <= i1 + x;
                i2 <= i2 + i1;
                i3 <= i3 + i2;
                phase <= phase + 1'b1;
            end
            dec <= io.bit_en_i & (&phase);
            if (dec) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                io.sample_o <= sat;
            end
            io.sample_valid_o <= dec | (io.sample_valid_o & ~io.sample_ready_i);
            io.overrun_o <= dec & io.sample_valid_o & ~io.sample_ready_i;
        end
    end
endmodule

// File: tb/tb_sigma_delta_decimator.sv
// tb_sigma_delta_decimator: table-driven steady-state vectors plus overrun and mid-frame reset sequences.
module tb_sigma_delta_decimator;
    typedef struct {
        string      name;
        logic [3:0] pat;
        int         plen;
        int         en_div;
        longint     exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    longint m1, m2, m3, h1, h2, h3;
    int mph;
    longint exp_q[$];
    vec_t tbl[5];
    sigma_delta_decimator_if #(.BW(16)) io ();
    sigma_delta_decimator #(.BW(16), .LOG2R(6)) dut (.clk(clk), .rst_n(rst_n), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    function automatic longint scale(input longint y);
        longint v;
`ifdef SIGMA_DELTA_DECIM_ROUND_EN
        v = (y + 4) >>> 3;
`else
        v = y >>> 3;
`endif
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction
    function automatic void model_reset();
        m1 = 0; m2 = 0; m3 = 0; h1 = 0; h2 = 0; h3 = 0; mph = 0;
        exp_q.delete();
    endfunction
    // Unbounded integrators and a direct-form 3rd difference of the decimated third integrator.
    function automatic void model_bit(input logic b);
        longint n1, n2, n3;
        n1 = m1 + (b ? 1 : -1);
        n2 = m2 + m1;
        n3 = m3 + m2;
        m1 = n1; m2 = n2; m3 = n3;
        mph++;
        if (mph == 64) begin
            mph = 0;
            exp_q.push_back(scale(m3 - 3*h1 + 3*h2 - h3));
            h3 = h2; h2 = h1; h1 = m3;
        end
    endfunction
    task automatic tick(input logic b, input logic e);
        io.bit_i = b;
        io.bit_en_i = e;
        if (e) model_bit(b);
        @(posedge clk);
        #1;
    endtask
    function automatic longint smp();
        return longint'($signed(io.sample_o));
    endfunction
    task automatic do_reset();
        io.bit_i = 1'b0;
        io.bit_en_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask
    task automatic run_entry(input vec_t v);
        int k = 0, n = 0, last = 0;
        logic e, b;
        longint want;
        do_reset();
        io.sample_ready_i = 1'b1;
        for (int c = 0; c < 6*64*v.en_div + 20 && n < 5; c++) begin
            e = (c % v.en_div) == 0;
            b = e ? v.pat[k % v.plen] : ~v.pat[k % v.plen];
            tick(b, e);
            if (e) k++;
            if (io.sample_valid_o) begin
                n++;
                want = exp_q.size() > 0 ? exp_q.pop_front() : 64'sh7fff_ffff;
                chk({v.name, " model"}, smp(), want);
                if (n >= 4) chk({v.name, " steady"}, smp(), v.exp);
                if (n >= 2) chk({v.name, " interval"}, c - last, 64*v.en_div);
                last = c;
            end
        end
        if (n < 5) chk({v.name, " sample count (timeout)"}, n, 5);
    endtask
    initial begin
        int ov;
        int n;
        tbl[0] = '{"const1", 4'b0001, 1, 1, 32767};
        tbl[1] = '{"const0", 4'b0000, 1, 1, -32768};
        tbl[2] = '{"alt10",  4'b0001, 2, 1, 0};
        tbl[3] = '{"p1110",  4'b0111, 4, 1, 16384};
        tbl[4] = '{"en3",    4'b0001, 1, 3, 32767};
        io.sample_ready_i = 1'b0;
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset sample", smp(), 0);
        chk("reset valid", longint'(io.sample_valid_o), 0);
        chk("reset overrun", longint'(io.overrun_o), 0);
        for (int i = 0; i < 5; i++) run_entry(tbl[i]);
        // Overrun: ready low across two loads, then ready rising on the third load.
        do_reset();
        io.sample_ready_i = 1'b0;
        ov = 0;
        for (int t = 1; t <= 192; t++) begin
            tick(1'b1, 1'b1);
            ov += int'(io.overrun_o);
            if (t == 65) chk("ovr first valid", longint'(io.sample_valid_o), 1);
            if (t == 128) chk("ovr hold first sample", smp(), exp_q[0]);
            if (t == 129) begin
                chk("ovr pulse", longint'(io.overrun_o), 1);
                chk("ovr valid stays", longint'(io.sample_valid_o), 1);
                chk("ovr second sample", smp(), exp_q[1]);
            end
            if (t == 130) chk("ovr one cycle", longint'(io.overrun_o), 0);
        end
        chk("ovr pulse count", ov, 1);
        io.sample_ready_i = 1'b1;
        tick(1'b1, 1'b1);
        chk("ready+load no overrun", longint'(io.overrun_o), 0);
        chk("ready+load valid", longint'(io.sample_valid_o), 1);
        chk("ready+load sample", smp(), exp_q[2]);
        tick(1'b1, 1'b1);
        chk("handshake clears valid", longint'(io.sample_valid_o), 0);
        // Asynchronous reset at phase 30 with a pending sample, then impulse response.
        do_reset();
        io.sample_ready_i = 1'b0;
        for (int t = 1; t <= 94; t++) tick(1'b1, 1'b1);
        chk("pre-reset valid", longint'(io.sample_valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset sample", smp(), 0);
        chk("async reset valid", longint'(io.sample_valid_o), 0);
        chk("async reset overrun", longint'(io.overrun_o), 0);
        io.bit_en_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        io.sample_ready_i = 1'b1;
        n = 0;
        for (int t = 1; t <= 4*64 + 10 && n < 4; t++) begin
            tick(t == 1, 1'b1);
            if (t == 64) chk("no early sample", longint'(io.sample_valid_o), 0);
            if (t == 65) chk("first sample after 64 bits", longint'(io.sample_valid_o), 1);
            if (io.sample_valid_o) begin
                n++;
                chk("impulse model", smp(), exp_q.size() > 0 ? exp_q.pop_front() : 64'sh7fff_ffff);
            end
        end
        if (n < 4) chk("impulse sample count (timeout)", n, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 The block SHALL have parameter BW, default 16, meaning the width of the signed output sample.
REQ-002 The block SHALL have parameter LOG2R, default 6, meaning the log2 of the decimation ratio R (R = 64 by default).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port bit_i, input, 1 bit, the modulator bitstream.
REQ-006 The block SHALL have port bit_en_i, input, 1 bit, a strobe marking the cycles in which bit_i is valid.
REQ-007 The block SHALL have port sample_o, output, BW bits, the signed two's-complement decimated sample.
REQ-008 The block SHALL have port sample_valid_o, output, 1 bit, asserted while sample_o holds an unconsumed sample.
REQ-009 The block SHALL have port sample_ready_i, input, 1 bit, the downstream acceptance signal.
REQ-010 The block SHALL have port overrun_o, output, 1 bit, a one-cycle pulse when an unconsumed sample is overwritten.

Function
REQ-011 The block SHALL map each accepted bit to +1 when bit_i=1 and to -1 when bit_i=0; bit_i SHALL be ignored when bit_en_i=0.
REQ-012 The block SHALL implement a 3rd-order CIC decimator: three cascaded integrators updated only on accepted bits, decimation by R, then three cascaded combs with differential delay 1.
REQ-013 The internal width SHALL be W = 3*LOG2R + 2 signed bits; integrators SHALL wrap modulo 2^W, and the comb outputs SHALL remain exact.
REQ-014 A phase counter of LOG2R bits SHALL count accepted bits, wrap from R-1 to 0, and raise a decimation event on the accepted bit that wraps it.
REQ-015 On the edge after a decimation event, the comb stages SHALL update from the third integrator value, and the scaled result SHALL load into sample_o with sample_valid_o set (one-cycle latency).
REQ-016 Scaling SHALL use an arithmetic shift right by S = 3*LOG2R - (BW-1) (S = 3 by default), then saturate to [-2^(BW-1), 2^(BW-1)-1].
REQ-017 The handshake SHALL complete when sample_valid_o=1 and sample_ready_i=1 on the same edge; sample_valid_o SHALL then clear unless a new sample loads on that edge.
REQ-018 When a new sample loads while sample_valid_o=1 and sample_ready_i=0, the new sample SHALL overwrite the old one, sample_valid_o SHALL stay 1, and overrun_o SHALL pulse high for one cycle.
REQ-019 When a new sample loads on the same edge as a completed handshake, there SHALL be no overrun and sample_valid_o SHALL stay 1.
REQ-020 sample_o SHALL hold its value while sample_valid_o=1 and no new sample loads.
REQ-021 All decimated outputs, including the first 3 startup transients after reset, SHALL be emitted without suppression.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear the integrators, combs, phase counter, sample_o (0), sample_valid_o (0) and overrun_o (0), including mid-frame and mid-handshake.
REQ-023 After rst_n deasserts, the first accepted bit SHALL be phase 0.

Configuration
REQ-024 With macro SIGMA_DELTA_DECIM_ROUND_EN defined, the block SHALL add 2^(S-1) before the shift of REQ-016 (round half up) and then saturate; without it, the shift SHALL truncate toward minus infinity; when S=0, both builds SHALL behave identically.

Verification
REQ-025 Constant bit_i=1 with bit_en_i=1 every cycle, R=64: from the 4th sample on, sample_o SHALL be 32767 (saturated from +32768), with a valid pulse every 64 cycles.
REQ-026 Constant bit_i=0: from the 4th sample on, sample_o SHALL be -32768.
REQ-027 Alternating 1,0 bits: from the 4th sample on, sample_o SHALL be 0; a repeating 1,1,1,0 pattern SHALL give 16384.
REQ-028 bit_en_i every 3rd cycle with constant 1s: a sample SHALL appear every 192 cycles, and bits presented with bit_en_i=0 SHALL be shown to have no effect.
REQ-029 sample_ready_i held 0 across two decimation events: overrun_o SHALL pulse exactly once and sample_o SHALL hold the second sample; ready rising in the same cycle as the new sample load SHALL give no overrun.
REQ-030 rst_n pulsed low mid-frame (phase 30) with sample_valid_o=1: all outputs SHALL go to 0 immediately, the next sample SHALL arrive 64 accepted bits after release, and the impulse-response samples SHALL match a bit-exact model in both SIGMA_DELTA_DECIM_ROUND_EN builds.
